alu_mdu_exec: RTL and testbench

Parametrised execute-stage ALU with integrated decode, the next generation of the single-cycle aludec + ALU pair.
- Decodes ALUOp/funct3/funct7 into the full RV32I register/immediate ALU set and, when enabled, the RV32M multiply/divide set.
- Single-cycle ops return after 1 cycle. MUL/DIV ops run an iterative radix-2 datapath.
- Uses a valid/ready handshake on both sides, so it sits between the decode/register-read stage and the writeback stage of the multi-cycle core.

---
 rtl/alu_mdu_pkg.sv | 26 ++
 rtl/alu_op_decode.sv | 53 +++++
 rtl/alu_mdu_exec.sv | 176 +++++++++++++++++
 tb/tb_alu_mdu_exec.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mdu_pkg.sv
// rtl/alu_mdu_pkg.sv - shared types and encodings for the execute-stage ALU/MDU
// Contents: ALUOp encodings, alu_op_e (decoded operation), state_e (exec FSM),
//           is_mul/is_div classification helpers.
package alu_mdu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILLEGAL
  } alu_op_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  function automatic logic is_mul(alu_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

  function automatic logic is_div(alu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational ALUOp/funct decode to alu_op_e
// Ports: ALUOp, funct3, funct7b5, funct7b0, Opb5 in; op out (OP_ILLEGAL for
//        reserved ALUOp or M encodings when EN_M=0).
module alu_op_decode
  import alu_mdu_pkg::*;
#(
  parameter bit EN_M = 1'b1
) (
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       funct7b0,
  input  logic       Opb5,
  output alu_op_e    op
);

  always_comb begin
    op = OP_ILLEGAL;
    case (ALUOp)
      ALUOP_ADD: op = OP_ADD;
      ALUOP_SUB: op = OP_SUB;
      ALUOP_FUNCT: begin
        if (Opb5 & funct7b0) begin
          if (EN_M) begin
            case (funct3)
              3'b000:  op = OP_MUL;
              3'b001:  op = OP_MULH;
              3'b010:  op = OP_MULHSU;
              3'b011:  op = OP_MULHU;
              3'b100:  op = OP_DIV;
              3'b101:  op = OP_DIVU;
              3'b110:  op = OP_REM;
              default: op = OP_REMU;
            endcase
          end
        end else begin
          case (funct3)
            3'b000:  op = (Opb5 & funct7b5) ? OP_SUB : OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = funct7b5 ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
          endcase
        end
      end
      default: op = OP_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_mdu_exec.sv
// rtl/alu_mdu_exec.sv - execute-stage ALU with iterative radix-2 multiply/divide
// Ports: clk, reset (async, active-high); in_valid/in_ready + ALUOp, funct3,
//        funct7b5, funct7b0, Opb5, srca, srcb on the input side;
//        out_valid/out_ready + result, zero, illegal on the output side.
module alu_mdu_exec
  import alu_mdu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            funct7b0,
  input  logic            Opb5,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SW = $clog2(XLEN);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state;
  alu_op_e         dec_op, op_q;
  logic [SW-1:0]   cnt;
  // hi/lo: product (hi:lo) for MUL; remainder (hi) and dividend->quotient (lo) for DIV
  logic [XLEN-1:0] hi, lo, opnd;
  logic            neg_q, rneg_q;

  alu_op_decode #(.EN_M(EN_M)) u_dec (
    .ALUOp(ALUOp), .funct3(funct3), .funct7b5(funct7b5),
    .funct7b0(funct7b0), .Opb5(Opb5), .op(dec_op)
  );

  assign in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
  assign out_valid = (state == S_DONE);

  logic accept;
  assign accept = in_valid & in_ready;

  // Operand signs and magnitudes at accept
  logic            a_neg, b_neg, div_zero, div_ovf, fast;
  logic [XLEN-1:0] mag_a, mag_b, one_res;
  logic [SW-1:0]   shamt;

  always_comb begin
    a_neg    = srca[XLEN-1] & ((dec_op == OP_MULH) | (dec_op == OP_MULHSU) |
                               (dec_op == OP_DIV) | (dec_op == OP_REM));
    b_neg    = srcb[XLEN-1] & ((dec_op == OP_MULH) | (dec_op == OP_DIV) | (dec_op == OP_REM));
    mag_a    = a_neg ? -srca : srca;
    mag_b    = b_neg ? -srcb : srcb;
    div_zero = (srcb == '0);
    div_ovf  = ((dec_op == OP_DIV) | (dec_op == OP_REM)) & (srca == XMIN) & (&srcb);
    fast     = div_zero | div_ovf;
    shamt    = srcb[SW-1:0];
  end

  // Single-cycle results, including the divide special cases
  always_comb begin
    one_res = '0;
    case (dec_op)
      OP_ADD:            one_res = srca + srcb;
      OP_SUB:            one_res = srca - srcb;
      OP_SLL:            one_res = srca << shamt;
      OP_SLT:            one_res = {{(XLEN-1){1'b0}}, $signed(srca) < $signed(srcb)};
      OP_SLTU:           one_res = {{(XLEN-1){1'b0}}, srca < srcb};
      OP_XOR:            one_res = srca ^ srcb;
      OP_SRL:            one_res = srca >> shamt;
      OP_SRA:            one_res = $unsigned($signed(srca) >>> shamt);
      OP_OR:             one_res = srca | srcb;
      OP_AND:            one_res = srca & srcb;
      OP_DIV, OP_DIVU:   one_res = div_ovf ? XMIN : '1;
      OP_REM, OP_REMU:   one_res = div_ovf ? '0 : srca;
      default:           one_res = '0;
    endcase
  end

  // One iteration step of shift-add multiply or restoring divide
  logic [XLEN:0]   mul_sum, div_sh;
  logic [XLEN-1:0] hi_n, lo_n, q_fin, r_fin, fin_res;
  logic [2*XLEN-1:0] prod, sprod;
  logic            div_ge;

  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_sh  = {hi, lo[XLEN-1]};
    div_ge  = div_sh >= {1'b0, opnd};
    if (state == S_MUL) begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo[XLEN-1:1]};
    end else begin
      // when div_ge the difference is below opnd, so the low XLEN bits suffice
      hi_n = div_ge ? (div_sh[XLEN-1:0] - opnd) : div_sh[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], div_ge};
    end
    prod  = {hi_n, lo_n};
    sprod = neg_q ? -prod : prod;
    q_fin = neg_q ? -lo_n : lo_n;
    r_fin = rneg_q ? -hi_n : hi_n;
    case (op_q)
      OP_MUL:                       fin_res = sprod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = sprod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fin_res = q_fin;
      OP_REM, OP_REMU:              fin_res = r_fin;
      default:                      fin_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      op_q    <= OP_ADD;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      opnd    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            op_q <= dec_op;
            cnt  <= '0;
            if (is_mul(dec_op)) begin
              hi    <= '0;
              lo    <= mag_b;
              opnd  <= mag_a;
              neg_q <= a_neg ^ b_neg;
              state <= S_MUL;
            end else if (is_div(dec_op) && !fast) begin
              hi     <= '0;
              lo     <= mag_a;
              opnd   <= mag_b;
              neg_q  <= a_neg ^ b_neg;
              rneg_q <= a_neg;
              state  <= S_DIV;
            end else begin
              result  <= one_res;
              zero    <= (one_res == '0);
              illegal <= (dec_op == OP_ILLEGAL);
              state   <= S_DONE;
            end
          end else if (state == S_DONE && out_ready) begin
            state <= S_IDLE;
          end
        end
        S_MUL, S_DIV: begin
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt + 1'b1;
          if (cnt == SW'(XLEN-1)) begin
            result  <= fin_res;
            zero    <= (fin_res == '0);
            illegal <= 1'b0;
            state   <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu_exec.sv
// tb/tb_alu_mdu_exec.sv - self-checking bench for alu_mdu_exec
module tb_alu_mdu_exec;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready0;
  logic [1:0]  ALUOp = 2'b00;
  logic [2:0]  funct3 = 3'b000;
  logic        funct7b5 = 1'b0, funct7b0 = 1'b0, Opb5 = 1'b0;
  logic [31:0] srca = '0, srcb = '0;
  logic        out_valid, out_valid0;
  logic        out_ready = 1'b1;
  logic [31:0] result, result0;
  logic        zero, zero0, illegal, illegal0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit rand_rdy = 0;
  bit cur_has_lit = 0;
  logic [31:0] cur_lit = '0;

  alu_mdu_exec #(.XLEN(32), .EN_M(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0),
    .Opb5(Opb5), .srca(srca), .srcb(srcb), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
  );

  alu_mdu_exec #(.XLEN(32), .EN_M(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .ALUOp(ALUOp), .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0),
    .Opb5(Opb5), .srca(srca), .srcb(srcb), .out_valid(out_valid0),
    .out_ready(1'b1), .result(result0), .zero(zero0), .illegal(illegal0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: what the instruction computes, from RISC-V arithmetic rules.
  // lat is the number of clocks between the accept edge and the edge that raises out_valid.
  task automatic model(input logic [1:0] aop, input logic [2:0] f3, input logic f7b5,
                       input logic f7b0, input logic opb5, input logic [31:0] a,
                       input logic [31:0] b, input bit en_m,
                       output logic [31:0] r, output logic ill, output int lat);
    longint sa, sb;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    r = '0; ill = 1'b0; lat = 0;
    if (aop == 2'b00) r = a + b;
    else if (aop == 2'b01) r = a - b;
    else if (aop == 2'b11) ill = 1'b1;
    else if (opb5 && f7b0) begin
      if (!en_m) ill = 1'b1;
      else begin
        case (f3)
          3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; lat = 32; end
          3'd1: begin p = sa * sb; r = p[63:32]; lat = 32; end
          3'd2: begin p = sa * longint'({32'b0, b}); r = p[63:32]; lat = 32; end
          3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; lat = 32; end
          3'd4: if (b == 0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
                else begin p = sa / sb; r = p[31:0]; lat = 32; end
          3'd5: if (b == 0) r = 32'hFFFFFFFF; else begin r = a / b; lat = 32; end
          3'd6: if (b == 0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 0;
                else begin p = sa % sb; r = p[31:0]; lat = 32; end
          default: if (b == 0) r = a; else begin r = a % b; lat = 32; end
        endcase
      end
    end else begin
      case (f3)
        3'd0: r = (opb5 && f7b5) ? a - b : a + b;
        3'd1: r = a << b[4:0];
        3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: begin
          p = {{32{a[31] & f7b5}}, a} >> b[4:0];
          r = p[31:0];
        end
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          acc;
    bit          has_lit;
    logic [31:0] lit;
  } exp_t;

  exp_t q[$];
  int head_first = -1;

  // Compare process: scoreboard for dut, one-cycle check for dut0, hold stability
  initial begin
    bit d0_prev = 0, hold_prev = 0;
    logic [31:0] d0_res, h_res;
    logic d0_ill, h_zero, h_ill;
    int d0_lat;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        q.delete();
        head_first = -1;
        d0_prev = 0;
        hold_prev = 0;
        continue;
      end
      if (d0_prev) begin
        chk("d0_valid", {31'b0, out_valid0}, 32'd1);
        chk("d0_result", result0, d0_res);
        chk("d0_illegal", {31'b0, illegal0}, {31'b0, d0_ill});
      end
      d0_prev = in_valid && in_ready0;
      if (d0_prev) model(ALUOp, funct3, funct7b5, funct7b0, Opb5, srca, srcb, 0, d0_res, d0_ill, d0_lat);

      if (hold_prev) begin
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
        chk("hold_result", result, h_res);
        chk("hold_flags", {30'b0, zero, illegal}, {30'b0, h_zero, h_ill});
      end
      if (out_valid && !out_ready) chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      hold_prev = out_valid && !out_ready;
      h_res = result; h_zero = zero; h_ill = illegal;

      if (out_valid && q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_output: got out_valid=1 expected no pending op");
      end
      if (out_valid && q.size() > 0 && head_first < 0) head_first = cyc;
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("result", result, e.res);
        chk("zero", {31'b0, zero}, {31'b0, e.res == 0});
        chk("illegal", {31'b0, illegal}, {31'b0, e.ill});
        chk("latency", head_first - e.acc, e.lat);
        if (e.has_lit) chk("literal", result, e.lit);
        head_first = -1;
      end
      if (in_valid && in_ready) begin
        model(ALUOp, funct3, funct7b5, funct7b0, Opb5, srca, srcb, 1, e.res, e.ill, e.lat);
        e.acc = cyc + 1;
        e.has_lit = cur_has_lit;
        e.lit = cur_lit;
        q.push_back(e);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge right after the accept edge
  task automatic send(input logic [1:0] aop, input logic [2:0] f3, input logic f7b5,
                      input logic f7b0, input logic opb5, input logic [31:0] a,
                      input logic [31:0] b, input bit has_lit, input logic [31:0] lit);
    int n = 0;
    ALUOp = aop; funct3 = f3; funct7b5 = f7b5; funct7b0 = f7b0; Opb5 = opb5;
    srca = a; srcb = b; cur_has_lit = has_lit; cur_lit = lit;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return $urandom_range(0, 15);
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before 90000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {30'b0, zero, illegal}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;

    send(2'b10, 3'b000, 1, 0, 1, 32'd5, 32'd7, 1, 32'hFFFFFFFE);
    send(2'b10, 3'b101, 1, 0, 1, 32'h80000000, 32'h24, 1, 32'hF8000000);
    send(2'b10, 3'b011, 0, 0, 1, 32'd1, 32'hFFFFFFFF, 1, 32'd1);
    send(2'b10, 3'b001, 0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'd0);
    #1;
    chk("d0_mulh_illegal", {31'b0, illegal0}, 32'd1);
    chk("d0_mulh_result", result0, 32'd0);
    send(2'b10, 3'b011, 0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE);
    send(2'b10, 3'b100, 0, 1, 1, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFD);
    send(2'b10, 3'b110, 0, 1, 1, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF);
    send(2'b10, 3'b101, 0, 1, 1, 32'd1234, 32'd0, 1, 32'hFFFFFFFF);
    send(2'b10, 3'b100, 0, 1, 1, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000);
    send(2'b11, 3'b000, 0, 0, 0, 32'd9, 32'd9, 1, 32'd0);

    // Stall a finished DIV, then release with a back-to-back ADD
    repeat (40) @(negedge clk);
    out_ready = 1'b0;
    send(2'b10, 3'b100, 0, 1, 1, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFD);
    repeat (37) @(negedge clk);
    #1;
    chk("stall_valid", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    send(2'b00, 3'b000, 0, 0, 0, 32'd2, 32'd3, 1, 32'd5);

    // Reset in the middle of a divide
    repeat (3) @(negedge clk);
    send(2'b10, 3'b101, 0, 1, 1, 32'd100000, 32'd7, 0, 32'd0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send(2'b00, 3'b000, 0, 0, 0, 32'd40, 32'd2, 1, 32'd42);

    // Randomized traffic with random consumer back-pressure
    rand_rdy = 1;
    for (int i = 0; i < 150; i++) begin
      logic [1:0] aop;
      int w = $urandom_range(0, 9);
      aop = (w == 0) ? 2'b00 : (w == 1) ? 2'b01 : (w == 9) ? 2'b11 : 2'b10;
      send(aop, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), pick(), pick(), 0, 32'd0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    rand_rdy = 0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk); n++;
    end
    if (q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
